mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for bridged memory cycles. It sits on the MEMDATA side of the memory bridge, opposite the MainBus. It turns a four-phase request/ready handshake into correctly sequenced asynchronous SRAM strobes with a programmable number of wait states. It also drives read data back onto MEMDATA for the bridge to pass to MainBus.

## Interface
- WAIT_STATES, 1: extra strobe cycles beyond the first; legal range 0..15. Elaboration fails outside this range.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high.
- MemReq  in  1  request level. Held high by the initiator until MemReady is seen.
- MemDir  in  1  1 = read (SRAM -> MEMDATA), 0 = write (MEMDATA -> SRAM); same sense as the bridge direction.
- MemAddr  in  16  cycle address.
- MemData_In  in  8  value present on MEMDATA when the bridge drives it.
- MemData_Out  out  8  read data toward MEMDATA.
- MemData_OE  out  1  enables the MEMDATA driver; top-level tristate only.
- MemReady  out  1  cycle complete.
- MemBusy  out  1  high in any state except IDLE.
- SramAddr  out  16  SRAM address.
- SramData_In  in  8  SRAM data pins, read side.
- SramData_Out  out  8  SRAM write data.
- SramData_OE  out  1  enables the SRAM data driver.
- Sram_CE_n, Sram_OE_n, Sram_WE_n  out  1 each  SRAM strobes, active-low.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, ACK.
- All outputs are registered or a pure decode of registered state.
- IDLE
  - When MemReq = 1, latch MemAddr, MemDir and MemData_In, then go to SETUP.
  - Inputs are ignored at all other times; mid-cycle address or data changes have no effect.
- SETUP (1 cycle)
  - SramAddr valid, Sram_CE_n = 0.
  - On a write, SramData_OE = 1 with the latched data.
  - Wait counter loads WAIT_STATES.
  - Next state: STROBE.
- STROBE (WAIT_STATES+1 cycles)
  - Read: Sram_OE_n = 0.
  - Write: Sram_WE_n = 0, SramData_OE = 1.
  - Counter decrements each cycle. When the counter = 0, go to HOLD.
  - On a read, SramData_In is captured into the read latch on that same edge.
- HOLD (1 cycle)
  - All strobes high except Sram_CE_n = 0.
  - On a write, SramData_OE stays 1 (data hold time).
  - Next state: ACK.
- ACK
  - MemReady = 1, Sram_CE_n = 1.
  - On a read, MemData_OE = 1 and MemData_Out = read latch.
  - Stay in ACK while MemReq = 1. When MemReq = 0, go to IDLE.
- MemReq dropping before ACK does not abort the cycle. ACK then lasts exactly one cycle, giving a one-cycle MemReady pulse.
- MemData_OE and SramData_OE are never high together.
- Sram_OE_n and Sram_WE_n are never low together.

## Timing
- Reset values: MemReady = 0, MemBusy = 0, MemData_OE = 0, SramData_OE = 0, all strobes = 1, SramAddr = 0, MemData_Out = 0, SramData_Out = 0; state = IDLE.
- Reset mid-cycle: on the next edge all strobes are high, both OEs are low, and state is IDLE. No partial write completes after the reset edge.
- Latency, with the edge that samples MemReq as edge 0:
  - SETUP follows edge 0.
  - STROBE covers edges 1 .. 1+WAIT_STATES.
  - HOLD follows edge 2+WAIT_STATES.
  - MemReady is high after edge 3+WAIT_STATES.
- Back-to-back requests: at least one IDLE cycle separates cycles. A new MemReq is sampled no earlier than the edge after MemReq = 0 is seen in ACK.
- Counter is 4 bits and never wraps: it loads in SETUP and stops at 0.

## Structure
- Package mem_pkg:
  - state enum (IDLE, SETUP, STROBE, HOLD, ACK);
  - MEM_DIR_READ = 1'b1 and MEM_DIR_WRITE = 1'b0;
  - WAIT_MAX = 15.
- Sub-module mem_wait_timer: 4-bit loadable down-counter with a zero flag. Load and decrement enables come from the FSM.
- The top-level wrapper owns the tristates on MEMDATA and the SRAM data pins. This block has no inout ports.

## Test plan
- Read, WAIT_STATES=1
  - Stimulus: addr 0x1234; SRAM model returns 0xA5.
  - Required: Sram_OE_n low for exactly 2 cycles; MemReady rises after edge 4; MemData_Out = 0xA5 with MemData_OE = 1 until MemReq falls.
- Write, WAIT_STATES=0
  - Stimulus: addr 0x00FF, data 0x3C.
  - Required: Sram_WE_n low for 1 cycle; SramData_OE high for SETUP, STROBE and HOLD (3 cycles); SRAM model holds 0x3C at 0x00FF.
- Early MemReq drop
  - Stimulus: MemReq held one cycle only, WAIT_STATES=3.
  - Required: cycle completes; MemReady is a 1-cycle pulse after edge 6; then IDLE.
- Input changes and back-to-back
  - Stimulus: change MemAddr and MemData_In during STROBE.
  - Required: SramAddr and SramData_Out are unchanged.
  - Stimulus: immediate second request.
  - Required: it is accepted only after one IDLE cycle.
- Reset during STROBE of a write
  - Required: next edge has Sram_WE_n = 1, SramData_OE = 0, MemBusy = 0; the SRAM location is unchanged unless it was already written.
- Invariant checks across random traffic, with WAIT_STATES = 0, 7 and 15:
  - MemData_OE and SramData_OE are never high together;
  - Sram_OE_n and Sram_WE_n are never low together.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-side responder.
//   memState_t     : responder FSM states
//   MEM_DIR_*      : MemDir encoding (1 = read from SRAM, 0 = write to SRAM)
//   WAIT_MAX       : largest legal WAIT_STATES value
//   COUNT_W        : width of the wait-state counter
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      ACK
   } memState_t;

   localparam logic MEM_DIR_READ  = 1'b1;
   localparam logic MEM_DIR_WRITE = 1'b0;
   localparam int   WAIT_MAX      = 15;
   localparam int   COUNT_W       = 4;

endpackage

// File: rtl/mem_responder_if.sv
// MEMDATA-side request/ready handshake between the memory bridge and the
// responder.
//   MemReq/MemDir/MemAddr/MemData_In     : driven by the initiator (master)
//   MemData_Out/MemData_OE/MemReady/MemBusy : driven by the responder (slave)
interface mem_responder_if;

   logic        MemReq;
   logic        MemDir;
   logic [15:0] MemAddr;
   logic [7:0]  MemData_In;
   logic [7:0]  MemData_Out;
   logic        MemData_OE;
   logic        MemReady;
   logic        MemBusy;

   modport master (
      output MemReq, MemDir, MemAddr, MemData_In,
      input  MemData_Out, MemData_OE, MemReady, MemBusy
   );

   modport slave (
      input  MemReq, MemDir, MemAddr, MemData_In,
      output MemData_Out, MemData_OE, MemReady, MemBusy
   );

endinterface

// File: rtl/mem_responder_wait_timer.sv
// Loadable 4-bit down-counter that times the SRAM strobe phase.
//   clk, reset : clock and synchronous active-high reset
//   load       : load loadValue (has priority over dec)
//   loadValue  : wait-state count to load
//   dec        : decrement by one; holds at zero instead of wrapping
//   isZero     : count is zero
module mem_wait_timer
   import mem_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [COUNT_W-1:0] loadValue,
   input  logic               dec,
   output logic               isZero
);

   logic [COUNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign isZero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: converts the four-phase MemReq/MemReady handshake
// into sequenced asynchronous SRAM strobes with WAIT_STATES extra strobe
// cycles, and returns read data toward MEMDATA.
//   Clk, Reset   : clock, synchronous active-high reset
//   memBus       : MEMDATA-side handshake (slave modport)
//   SramAddr     : latched SRAM address
//   SramData_In  : SRAM data pins, read side
//   SramData_Out : latched SRAM write data
//   SramData_OE  : SRAM data driver enable (write cycles only)
//   Sram_CE_n, Sram_OE_n, Sram_WE_n : active-low SRAM strobes
module mem_responder
   import mem_pkg::*;
#(
   parameter int WAIT_STATES = 1
)
(
   input  logic             Clk,
   input  logic             Reset,
   mem_responder_if.slave   memBus,
   output logic [15:0]      SramAddr,
   input  logic [7:0]       SramData_In,
   output logic [7:0]       SramData_Out,
   output logic             SramData_OE,
   output logic             Sram_CE_n,
   output logic             Sram_OE_n,
   output logic             Sram_WE_n
);

   if ((WAIT_STATES < 0) || (WAIT_STATES > WAIT_MAX)) begin : gBadWaitStates
      $error("mem_responder: WAIT_STATES must be in 0..15");
   end

   localparam logic [COUNT_W-1:0] WAIT_LOAD = COUNT_W'(WAIT_STATES);

   memState_t  state;
   memState_t  nextState;
   logic       dirLatch;
   logic [7:0] readLatch;
   logic       timerLoad;
   logic       timerDec;
   logic       timerZero;
   logic       isRead;
   logic       sramActive;

   mem_wait_timer waitTimer (
      .clk       (Clk),
      .reset     (Reset),
      .load      (timerLoad),
      .loadValue (WAIT_LOAD),
      .dec       (timerDec),
      .isZero    (timerZero)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Request fields are captured only on acceptance, so initiator changes
   // later in the cycle cannot disturb the SRAM side.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         dirLatch     <= MEM_DIR_WRITE;
         SramAddr     <= '0;
         SramData_Out <= '0;
         readLatch    <= '0;
      end else begin
         if ((state == IDLE) && memBus.MemReq) begin
            dirLatch     <= memBus.MemDir;
            SramAddr     <= memBus.MemAddr;
            SramData_Out <= memBus.MemData_In;
         end
         // Sample on the last strobe edge while Sram_OE_n is still low.
         if ((state == STROBE) && timerZero && (dirLatch == MEM_DIR_READ)) begin
            readLatch <= SramData_In;
         end
      end
   end

   always_comb begin
      nextState          = state;
      timerLoad          = 1'b0;
      timerDec           = 1'b0;
      isRead             = (dirLatch == MEM_DIR_READ);
      sramActive         = 1'b0;
      Sram_CE_n          = 1'b1;
      Sram_OE_n          = 1'b1;
      Sram_WE_n          = 1'b1;
      SramData_OE        = 1'b0;
      memBus.MemReady    = 1'b0;
      memBus.MemBusy     = 1'b1;
      memBus.MemData_OE  = 1'b0;
      memBus.MemData_Out = readLatch;

      unique case (state)
         IDLE: begin
            memBus.MemBusy = 1'b0;
            if (memBus.MemReq) begin
               nextState = SETUP;
            end
         end
         SETUP: begin
            sramActive = 1'b1;
            timerLoad  = 1'b1;
            nextState  = STROBE;
         end
         STROBE: begin
            sramActive = 1'b1;
            timerDec   = 1'b1;
            Sram_OE_n  = !isRead;
            Sram_WE_n  = isRead;
            if (timerZero) begin
               nextState = HOLD;
            end
         end
         HOLD: begin
            sramActive = 1'b1;
            nextState  = ACK;
         end
         ACK: begin
            memBus.MemReady   = 1'b1;
            memBus.MemData_OE = isRead;
            if (!memBus.MemReq) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase

      if (sramActive) begin
         Sram_CE_n   = 1'b0;
         SramData_OE = !isRead;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: five instances with WAIT_STATES of
// 0, 1, 3, 7 and 15, each with its own behavioural SRAM.
module tb_mem_responder;

   localparam int N = 5;
   localparam int WS [N] = '{0, 1, 3, 7, 15};

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic [N-1:0]       rst, req, dir, ready, busy, mOE, sOE, ceN, oeN, weN, pokeEn;
   logic [N-1:0][15:0] addr, sAddr, pokeAddr, peekAddr;
   logic [N-1:0][7:0]  din, dout, sDout, sDin, pokeData, peek;

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < N; g++) begin : gDut
      mem_responder_if memBus ();
      logic [7:0] mem [65536];

      assign memBus.MemReq     = req[g];
      assign memBus.MemDir     = dir[g];
      assign memBus.MemAddr    = addr[g];
      assign memBus.MemData_In = din[g];
      assign ready[g] = memBus.MemReady;
      assign busy[g]  = memBus.MemBusy;
      assign mOE[g]   = memBus.MemData_OE;
      assign dout[g]  = memBus.MemData_Out;

      mem_responder #(.WAIT_STATES(WS[g])) dut (
         .Clk          (Clk),
         .Reset        (rst[g]),
         .memBus       (memBus),
         .SramAddr     (sAddr[g]),
         .SramData_In  (sDin[g]),
         .SramData_Out (sDout[g]),
         .SramData_OE  (sOE[g]),
         .Sram_CE_n    (ceN[g]),
         .Sram_OE_n    (oeN[g]),
         .Sram_WE_n    (weN[g])
      );

      assign sDin[g] = (!ceN[g] && !oeN[g]) ? mem[sAddr[g]] : 8'h00;
      assign peek[g] = mem[peekAddr[g]];

      initial begin
         for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      end

      always @(posedge Clk) begin
         if (pokeEn[g]) mem[pokeAddr[g]] <= pokeData[g];
         else if (!ceN[g] && !weN[g]) mem[sAddr[g]] <= sDout[g];
      end
   end

   task automatic poke(input int k, input logic [15:0] a, input logic [7:0] d);
      @(negedge Clk);
      pokeAddr[k] = a; pokeData[k] = d; pokeEn[k] = 1'b1;
      @(negedge Clk);
      pokeEn[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst = '1; req = '0; dir = '0; addr = '0; din = '0;
      pokeEn = '0; pokeAddr = '0; pokeData = '0; peekAddr = '0;
      repeat (3) @(negedge Clk);
      rst = '0;
      @(negedge Clk);
      for (int k = 0; k < N; k++) begin
         checks++;
         if ({ready[k], busy[k], mOE[k], sOE[k]} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags k=%0d: ready/busy/mOE/sOE=%b required 0000", k, {ready[k], busy[k], mOE[k], sOE[k]});
         end
         checks++;
         if ({ceN[k], oeN[k], weN[k]} !== 3'b111) begin
            errors++; $display("FAIL reset_strobes k=%0d: ce/oe/we=%b required 111", k, {ceN[k], oeN[k], weN[k]});
         end
         checks++;
         if (sAddr[k] !== 16'h0000) begin
            errors++; $display("FAIL reset_addr k=%0d: got %h required 0000", k, sAddr[k]);
         end
         checks++;
         if ({dout[k], sDout[k]} !== 16'h0000) begin
            errors++; $display("FAIL reset_data k=%0d: MemData_Out=%h SramData_Out=%h required 00", k, dout[k], sDout[k]);
         end
      end
   endtask

   // WAIT_STATES = 1 read of 0xA5 from 0x1234
   task automatic test_read();
      int oeLow = 0;
      int first = -1;
      poke(1, 16'h1234, 8'hA5);
      addr[1] = 16'h1234; dir[1] = 1'b1; din[1] = 8'h00; req[1] = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge Clk);
         if (!oeN[1]) oeLow++;
         if (n == 0) begin
            checks++;
            if ({ceN[1], oeN[1], weN[1], busy[1], sOE[1], sAddr[1]} !== {5'b01110, 16'h1234}) begin
               errors++; $display("FAIL read_setup: ce/oe/we/busy/sOE=%b addr=%h required 01110 1234", {ceN[1], oeN[1], weN[1], busy[1], sOE[1]}, sAddr[1]);
            end
         end
         if (ready[1]) begin
            if (first < 0) first = n;
            checks++;
            if ({mOE[1], dout[1]} !== {1'b1, 8'hA5}) begin
               errors++; $display("FAIL read_data n=%0d: MemData_OE=%b MemData_Out=%h required 1 a5", n, mOE[1], dout[1]);
            end
         end
      end
      checks++;
      if (oeLow !== 2) begin
         errors++; $display("FAIL read_oe_cycles: got %0d required 2", oeLow);
      end
      checks++;
      if (first !== 4) begin
         errors++; $display("FAIL read_ready_edge: got %0d required 4", first);
      end
      req[1] = 1'b0;
      @(negedge Clk);
      checks++;
      if ({ready[1], mOE[1], busy[1]} !== 3'b000) begin
         errors++; $display("FAIL read_release: ready/mOE/busy=%b required 000", {ready[1], mOE[1], busy[1]});
      end
   endtask

   // WAIT_STATES = 0 write of 0x3C to 0x00FF
   task automatic test_write();
      int weLow = 0;
      int oeHigh = 0;
      int mOeHigh = 0;
      int first = -1;
      @(negedge Clk);
      addr[0] = 16'h00FF; dir[0] = 1'b0; din[0] = 8'h3C; req[0] = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge Clk);
         if (!weN[0]) weLow++;
         if (sOE[0]) oeHigh++;
         if (mOE[0]) mOeHigh++;
         if (ready[0] && first < 0) first = n;
         if (n == 1) begin
            checks++;
            if ({ceN[0], weN[0], oeN[0], sDout[0]} !== {3'b001, 8'h3C}) begin
               errors++; $display("FAIL write_strobe: ce/we/oe=%b data=%h required 001 3c", {ceN[0], weN[0], oeN[0]}, sDout[0]);
            end
         end
      end
      checks++;
      if (weLow !== 1) begin
         errors++; $display("FAIL write_we_cycles: got %0d required 1", weLow);
      end
      checks++;
      if (oeHigh !== 3) begin
         errors++; $display("FAIL write_sramoe_cycles: got %0d required 3", oeHigh);
      end
      checks++;
      if (mOeHigh !== 0) begin
         errors++; $display("FAIL write_memoe: got %0d cycles required 0", mOeHigh);
      end
      checks++;
      if (first !== 3) begin
         errors++; $display("FAIL write_ready_edge: got %0d required 3", first);
      end
      peekAddr[0] = 16'h00FF;
      req[0] = 1'b0;
      @(negedge Clk);
      checks++;
      if (peek[0] !== 8'h3C) begin
         errors++; $display("FAIL write_sram: got %h required 3c", peek[0]);
      end
   endtask

   // WAIT_STATES = 3, MemReq held for the accepting edge only
   task automatic test_early_drop();
      int cnt = 0;
      int first = -1;
      logic busyAt7 = 1'b1;
      @(negedge Clk);
      addr[2] = 16'h0010; dir[2] = 1'b0; din[2] = 8'h5A; req[2] = 1'b1;
      @(negedge Clk);
      req[2] = 1'b0;
      for (int n = 1; n < 12; n++) begin
         @(negedge Clk);
         if (ready[2]) begin
            cnt++;
            if (first < 0) first = n;
         end
         if (n == 7) busyAt7 = busy[2];
      end
      checks++;
      if (cnt !== 1) begin
         errors++; $display("FAIL early_ready_width: got %0d required 1", cnt);
      end
      checks++;
      if (first !== 6) begin
         errors++; $display("FAIL early_ready_edge: got %0d required 6", first);
      end
      checks++;
      if (busyAt7 !== 1'b0) begin
         errors++; $display("FAIL early_idle: busy=%b required 0", busyAt7);
      end
      peekAddr[2] = 16'h0010;
      #1;
      checks++;
      if (peek[2] !== 8'h5A) begin
         errors++; $display("FAIL early_sram: got %h required 5a", peek[2]);
      end
   endtask

   // WAIT_STATES = 7: inputs disturbed mid-cycle, then a fast second request
   task automatic test_back_to_back();
      int first = -1;
      @(negedge Clk);
      addr[3] = 16'h0200; dir[3] = 1'b0; din[3] = 8'h11; req[3] = 1'b1;
      for (int n = 0; n < 20 && first < 0; n++) begin
         @(negedge Clk);
         if (n == 2) begin
            addr[3] = 16'hBEEF; din[3] = 8'hEE;
         end
         if (n == 5) begin
            checks++;
            if ({sAddr[3], sDout[3], weN[3]} !== {16'h0200, 8'h11, 1'b0}) begin
               errors++; $display("FAIL b2b_strobe: addr=%h data=%h we=%b required 0200 11 0", sAddr[3], sDout[3], weN[3]);
            end
         end
         if (n == 9) begin
            checks++;
            if ({sAddr[3], ceN[3], weN[3], sOE[3]} !== {16'h0200, 3'b011}) begin
               errors++; $display("FAIL b2b_hold: addr=%h ce/we/sOE=%b required 0200 011", sAddr[3], {ceN[3], weN[3], sOE[3]});
            end
         end
         if (ready[3]) first = n;
      end
      checks++;
      if (first !== 10) begin
         errors++; $display("FAIL b2b_ready_edge: got %0d required 10", first);
      end
      addr[3] = 16'h0200; dir[3] = 1'b1; req[3] = 1'b0;
      @(negedge Clk);
      checks++;
      if ({busy[3], ready[3]} !== 2'b00) begin
         errors++; $display("FAIL b2b_idle_gap: busy/ready=%b required 00", {busy[3], ready[3]});
      end
      req[3] = 1'b1;
      @(negedge Clk);
      checks++;
      if ({busy[3], ceN[3], oeN[3], weN[3]} !== 4'b1011) begin
         errors++; $display("FAIL b2b_accept: busy/ce/oe/we=%b required 1011", {busy[3], ceN[3], oeN[3], weN[3]});
      end
      first = -1;
      for (int n = 1; n < 20 && first < 0; n++) begin
         @(negedge Clk);
         if (ready[3]) first = n;
      end
      checks++;
      if ({first, mOE[3], dout[3]} !== {32'd10, 1'b1, 8'h11}) begin
         errors++; $display("FAIL b2b_readback: edge=%0d mOE=%b data=%h required 10 1 11", first, mOE[3], dout[3]);
      end
      req[3] = 1'b0;
      peekAddr[3] = 16'hBEEF;
      @(negedge Clk);
      checks++;
      if (peek[3] !== 8'h00) begin
         errors++; $display("FAIL b2b_stray_write: mem[beef]=%h required 00", peek[3]);
      end
   endtask

   // WAIT_STATES = 15 write interrupted by reset in STROBE
   task automatic test_reset_strobe();
      @(negedge Clk);
      addr[4] = 16'h0400; dir[4] = 1'b0; din[4] = 8'h42; req[4] = 1'b1;
      repeat (3) @(negedge Clk);
      checks++;
      if ({weN[4], sOE[4]} !== 2'b01) begin
         errors++; $display("FAIL rst_pre: we/sOE=%b required 01", {weN[4], sOE[4]});
      end
      rst[4] = 1'b1;
      @(negedge Clk);
      checks++;
      if ({weN[4], sOE[4], busy[4], ceN[4], sAddr[4]} !== {4'b1001, 16'h0000}) begin
         errors++; $display("FAIL rst_mid: we/sOE/busy/ce=%b addr=%h required 1001 0000", {weN[4], sOE[4], busy[4], ceN[4]}, sAddr[4]);
      end
      rst[4] = 1'b0; req[4] = 1'b0;
      repeat (3) @(negedge Clk);
      checks++;
      if ({busy[4], weN[4], ceN[4]} !== 3'b011) begin
         errors++; $display("FAIL rst_after: busy/we/ce=%b required 011", {busy[4], weN[4], ceN[4]});
      end
   endtask

   // Random reads/writes over 0x0500..0x0507 against a shadow memory
   task automatic test_random();
      int ks [3] = '{0, 3, 4};
      int k;
      logic [7:0] sh [8];
      logic [2:0] a;
      logic [7:0] v;
      logic isRd, early, seen, done;
      int hold, ackLeft;
      for (int j = 0; j < 3; j++) begin
         k = ks[j];
         for (int i = 0; i < 8; i++) sh[i] = 8'h00;
         for (int t = 0; t < 24; t++) begin
            @(negedge Clk);
            a = 3'($urandom_range(0, 7));
            v = 8'($urandom);
            isRd = 1'($urandom_range(0, 1));
            early = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(0, 2);
            addr[k] = {13'h00A0, a}; dir[k] = isRd; din[k] = v; req[k] = 1'b1;
            seen = 1'b0; done = 1'b0; ackLeft = 0;
            for (int n = 0; n < WS[k] + 16 && !done; n++) begin
               @(negedge Clk);
               checks++;
               if (mOE[k] && sOE[k]) begin
                  errors++; $display("FAIL inv_oe k=%0d t=%0d: mOE=%b sOE=%b required not both 1", k, t, mOE[k], sOE[k]);
               end
               checks++;
               if (!oeN[k] && !weN[k]) begin
                  errors++; $display("FAIL inv_strobe k=%0d t=%0d: oe=%b we=%b required not both 0", k, t, oeN[k], weN[k]);
               end
               if (early && n == 0) req[k] = 1'b0;
               if (!seen && ready[k]) begin
                  seen = 1'b1;
                  ackLeft = early ? 0 : hold;
                  if (isRd) begin
                     checks++;
                     if (dout[k] !== sh[a]) begin
                        errors++; $display("FAIL rand_read k=%0d addr=%h: got %h required %h", k, addr[k], dout[k], sh[a]);
                     end
                  end
               end
               if (seen && !busy[k]) done = 1'b1;
               else if (seen) begin
                  if (ackLeft == 0) req[k] = 1'b0;
                  else ackLeft--;
               end
            end
            checks++;
            if (!done) begin
               errors++; $display("FAIL rand_timeout k=%0d t=%0d: ready=%b busy=%b required cycle to complete", k, t, seen, busy[k]);
            end
            req[k] = 1'b0;
            if (!isRd) sh[a] = v;
         end
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_early_drop();
      test_back_to_back();
      test_reset_strobe();
      test_random();
      repeat (2) @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
